devices_mux: RTL and testbench

- Parametrised successor to the fixed slot-device combiner.
- Combines N sound sources into one output through a registered, per-channel-attenuated, saturating mixer.
- Resolves the shared CPU read-data bus with priority on output-enable requests.
- Arbitrates N_RAM device RAM requesters onto the single SDRAM port with a round-robin FSM and timeout.
- Sits between the per-device instances and the slot/memory controller.

---
 rtl/devices_mux_pkg.sv | 23 ++
 rtl/devices_mux_if.sv | 26 ++
 rtl/devices_mux_rr_arb.sv | 89 ++++++++
 rtl/devices_mux.sv | 121 ++++++++++++
 tb/tb_devices_mux.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/devices_mux_pkg.sv
// Shared types and helpers for the devices_mux slot-device combiner.
package devices_mux_pkg;

  localparam int SND_W  = 16;
  localparam int ADDR_W = 27;

  localparam logic signed [SND_W-1:0] SND_MAX = 16'sh7FFF;
  localparam logic signed [SND_W-1:0] SND_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_t;

  // Clamp a wide signed value into the signed 16-bit audio range.
  function automatic logic signed [SND_W-1:0] sat16(input logic signed [31:0] x);
    if (x > 32'sd32767)       return SND_MAX;
    else if (x < -32'sd32768) return SND_MIN;
    else                      return x[SND_W-1:0];
  endfunction

endpackage

// File: rtl/devices_mux_if.sv
// SDRAM request/response bundle between the device requesters, devices_mux and the memory controller.
interface devices_mux_if
  import devices_mux_pkg::*;
#(
  parameter int N_RAM = 2
);

  logic [N_RAM-1:0]        ram_req;
  logic [N_RAM*ADDR_W-1:0] ram_addr_in;
  logic                    ram_ready;
  logic                    ram_cs;
  logic [ADDR_W-1:0]       ram_addr;
  logic [N_RAM-1:0]        ram_gnt;
  logic                    ram_err;

  modport master (
    input  ram_req, ram_addr_in, ram_ready,
    output ram_cs, ram_addr, ram_gnt, ram_err
  );

  modport slave (
    output ram_req, ram_addr_in, ram_ready,
    input  ram_cs, ram_addr, ram_gnt, ram_err
  );

endinterface

// File: rtl/devices_mux_rr_arb.sv
// Round-robin SDRAM arbiter: IDLE -> ISSUE (one ram_cs cycle) -> WAIT until ram_ready or timeout.
module devices_mux_rr_arb
  import devices_mux_pkg::*;
#(
  parameter int N_RAM       = 2,
  parameter int RAM_TIMEOUT = 255
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  devices_mux_if.master ram
);

  localparam int IDX_W = (N_RAM > 1) ? $clog2(N_RAM) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  arb_state_t        state, state_nx;
  idx_t              last, idx, sel;
  logic              sel_vld;
  logic [15:0]       cnt;
  logic              ready_seen;
  logic [ADDR_W-1:0] addr_q;
  logic              done;
  int                cand;

  // Search downward so the nearest requester after 'last' is the final write and wins.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    cand    = 0;
    for (int k = N_RAM; k >= 1; k--) begin
      cand = (int'(last) + k) % N_RAM;
      if (ram.ram_req[cand]) begin
        sel     = idx_t'(cand);
        sel_vld = 1'b1;
      end
    end
  end

  assign done = (state == ARB_WAIT) && (ram.ram_ready || ready_seen || (cnt == 16'd0));

  always_comb begin
    state_nx = state;
    unique case (state)
      ARB_IDLE:  if (sel_vld) state_nx = ARB_ISSUE;
      ARB_ISSUE: state_nx = ARB_WAIT;
      ARB_WAIT:  if (done) state_nx = ARB_IDLE;
      default:   state_nx = ARB_IDLE;
    endcase
  end

  assign ram.ram_cs   = (state == ARB_ISSUE);
  assign ram.ram_addr = addr_q;
  assign ram.ram_gnt  = done ? (N_RAM'(1) << idx) : '0;
  assign ram.ram_err  = done && !ram.ram_ready && !ready_seen;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB_IDLE;
      last       <= idx_t'(N_RAM - 1);
      idx        <= '0;
      addr_q     <= '0;
      cnt        <= '0;
      ready_seen <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        ARB_IDLE: if (sel_vld) begin
          idx    <= sel;
          addr_q <= ram.ram_addr_in[int'(sel)*ADDR_W +: ADDR_W];
        end
        ARB_ISSUE: begin
          cnt        <= 16'(RAM_TIMEOUT);
          ready_seen <= ram.ram_ready;
        end
        ARB_WAIT: begin
          if (cnt != 16'd0) cnt <= cnt - 16'd1;
          if (done) begin
            last       <= idx;
            ready_seen <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/devices_mux.sv
// Slot-device combiner: saturating sound mixer, read-data bus resolver and SDRAM arbiter.
// Optional DC blocker after the mixer is enabled with `define DEVICES_MUX_DC_BLOCK_EN.
module devices_mux
  import devices_mux_pkg::*;
#(
  parameter int N_SND       = 4,
  parameter int N_DEV       = 4,
  parameter int N_RAM       = 2,
  parameter int RAM_TIMEOUT = 255
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    sample_ce,
  input  logic [N_SND*SND_W-1:0]  snd_in,
  input  logic [N_SND*2-1:0]      snd_att,
  input  logic [N_DEV*8-1:0]      data_in,
  input  logic [N_DEV-1:0]        data_oe_in,
  output logic signed [SND_W-1:0] sound,
  output logic                    sat,
  output logic [7:0]              data,
  output logic                    data_oe_rq,
  devices_mux_if.master           ram
);

  localparam int SUM_W = SND_W + $clog2(N_SND) + 1;

  // Read-data bus: lowest-index output-enable wins, otherwise wired-AND of idle-high sources.
  always_comb begin
    data = 8'hFF;
    for (int i = 0; i < N_DEV; i++) data = data & data_in[i*8 +: 8];
    for (int i = N_DEV - 1; i >= 0; i--)
      if (data_oe_in[i]) data = data_in[i*8 +: 8];
  end

  assign data_oe_rq = |data_oe_in;

  logic signed [SND_W-1:0] s1 [N_SND];
  logic                    v1;
  logic signed [SUM_W-1:0] sum;
  logic signed [31:0]      sum_ext;
  logic signed [SND_W-1:0] mix_sat;
  logic                    mix_clip;

  // NOTE: the stage-1 array is a handful of flops, not a RAM, so it is reset like any register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0;
      for (int i = 0; i < N_SND; i++) s1[i] <= '0;
    end else begin
      v1 <= sample_ce;
      if (sample_ce)
        for (int i = 0; i < N_SND; i++)
          s1[i] <= $signed(snd_in[i*SND_W +: SND_W]) >>> snd_att[2*i +: 2];
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_SND; i++) sum = sum + SUM_W'(s1[i]);
    sum_ext  = 32'(sum);
    mix_sat  = sat16(sum_ext);
    mix_clip = (32'(mix_sat) != sum_ext);
  end

`ifdef DEVICES_MUX_DC_BLOCK_EN
  logic signed [SND_W-1:0] x_q, x_prev, y_prev, dc_sat;
  logic                    v2, clip2_q, dc_clip;
  logic signed [17:0]      dc_y;

  // y = x - x_prev + y_prev - y_prev/256, one-pole high-pass in 18 bits.
  always_comb begin
    dc_y    = 18'(x_q) - 18'(x_prev) + 18'(y_prev) - 18'(y_prev >>> 8);
    dc_sat  = sat16(32'(dc_y));
    dc_clip = (32'(dc_sat) != 32'(dc_y));
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= '0;
      clip2_q <= 1'b0;
      v2      <= 1'b0;
      x_prev  <= '0;
      y_prev  <= '0;
      sound   <= '0;
      sat     <= 1'b0;
    end else begin
      v2  <= v1;
      sat <= v2 && (clip2_q || dc_clip);
      if (v1) begin
        x_q     <= mix_sat;
        clip2_q <= mix_clip;
      end
      if (v2) begin
        sound  <= dc_sat;
        x_prev <= x_q;
        y_prev <= dc_sat;
      end
    end
  end
`else
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sound <= '0;
      sat   <= 1'b0;
    end else begin
      sat <= v1 && mix_clip;
      if (v1) sound <= mix_sat;
    end
  end
`endif

  devices_mux_rr_arb #(
    .N_RAM       (N_RAM),
    .RAM_TIMEOUT (RAM_TIMEOUT)
  ) u_rr_arb (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ram     (ram)
  );

endmodule

// File: tb/tb_devices_mux.sv
// Directed self-checking bench for devices_mux: mixer, data bus, round-robin, timeout, async reset.
module tb_devices_mux;
  import devices_mux_pkg::*;

  localparam int N_SND       = 4;
  localparam int N_DEV       = 4;
  localparam int N_RAM       = 2;
  localparam int RAM_TIMEOUT = 4;

  logic                    clk_sys = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    sample_ce = 1'b0;
  logic [N_SND*SND_W-1:0]  snd_in = '0;
  logic [N_SND*2-1:0]      snd_att = '0;
  logic [N_DEV*8-1:0]      data_in = '1;
  logic [N_DEV-1:0]        data_oe_in = '0;
  logic signed [SND_W-1:0] sound;
  logic                    sat;
  logic [7:0]              data;
  logic                    data_oe_rq;

  localparam logic [ADDR_W-1:0] ADDR0 = 27'h0AB_CDEF;
  localparam logic [ADDR_W-1:0] ADDR1 = 27'h123_4560;

  devices_mux_if #(.N_RAM(N_RAM)) ram_bus ();

  devices_mux #(
    .N_SND       (N_SND),
    .N_DEV       (N_DEV),
    .N_RAM       (N_RAM),
    .RAM_TIMEOUT (RAM_TIMEOUT)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .sample_ce  (sample_ce),
    .snd_in     (snd_in),
    .snd_att    (snd_att),
    .data_in    (data_in),
    .data_oe_in (data_oe_in),
    .sound      (sound),
    .sat        (sat),
    .data       (data),
    .data_oe_rq (data_oe_rq),
    .ram        (ram_bus)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // One sample through the mixer: sound must change exactly on the second edge.
  task automatic mix(input string tag, input logic [63:0] s, input logic [7:0] att,
                     input int prev, input int exp_snd, input logic exp_sat);
    snd_in    = s;
    snd_att   = att;
    sample_ce = 1'b1;
    tick();
    sample_ce = 1'b0;
    check({tag, "_stage1_sound"}, 32'(sound), 32'(prev));
    check({tag, "_stage1_sat"}, 32'(sat), 32'(1'b0));
    tick();
    check({tag, "_sound"}, 32'(sound), 32'(exp_snd));
    check({tag, "_sat"}, 32'(sat), 32'(exp_sat));
    tick();
    check({tag, "_hold_sound"}, 32'(sound), 32'(exp_snd));
    check({tag, "_hold_sat"}, 32'(sat), 32'(1'b0));
  endtask

  // One arbitrated access starting in IDLE with ram_ready returned 2 cycles after ram_cs.
  task automatic do_rr(input string tag, input int idx, input logic [ADDR_W-1:0] addr);
    logic [N_RAM-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    check({tag, "_idle_cs"}, 32'(ram_bus.ram_cs), 32'(1'b0));
    tick();
    check({tag, "_issue_cs"}, 32'(ram_bus.ram_cs), 32'(1'b1));
    check({tag, "_issue_addr"}, 32'(ram_bus.ram_addr), 32'(addr));
    tick();
    check({tag, "_wait_cs"}, 32'(ram_bus.ram_cs), 32'(1'b0));
    check({tag, "_wait_gnt"}, 32'(ram_bus.ram_gnt), 32'(0));
    tick();
    ram_bus.ram_ready = 1'b1;
    #1;
    check({tag, "_gnt"}, 32'(ram_bus.ram_gnt), 32'(oh));
    check({tag, "_err"}, 32'(ram_bus.ram_err), 32'(1'b0));
    tick();
    ram_bus.ram_ready = 1'b0;
  endtask

  initial begin
    ram_bus.ram_req     = '0;
    ram_bus.ram_addr_in = {ADDR1, ADDR0};
    ram_bus.ram_ready   = 1'b0;

    repeat (2) tick();
    check("rst_sound", 32'(sound), 32'(0));
    check("rst_sat", 32'(sat), 32'(1'b0));
    check("rst_cs", 32'(ram_bus.ram_cs), 32'(1'b0));
    check("rst_addr", 32'(ram_bus.ram_addr), 32'(0));
    check("rst_gnt", 32'(ram_bus.ram_gnt), 32'(0));
    check("rst_err", 32'(ram_bus.ram_err), 32'(1'b0));
    reset_n = 1'b1;
    tick();

    // Mixer: 1000+2000-500+0, then clip high, clip low, attenuated 4*5000.
    mix("mix_inrange", {16'(0), 16'(-500), 16'(2000), 16'(1000)}, 8'h00, 0, 2500, 1'b0);
    mix("mix_cliphi", {4{16'(20000)}}, 8'h00, 2500, 32767, 1'b1);
    mix("mix_cliplo", {4{16'(-20000)}}, 8'h00, 32767, -32768, 1'b1);
    mix("mix_att2", {4{16'(20000)}}, 8'b10101010, -32768, 20000, 1'b0);

    // Data bus: device0=12, device1=34, others idle FF.
    data_in    = {8'hFF, 8'hFF, 8'h34, 8'h12};
    data_oe_in = 4'b0010;
    #1;
    check("bus_oe1_data", 32'(data), 32'h34);
    check("bus_oe1_rq", 32'(data_oe_rq), 32'(1'b1));
    data_oe_in = 4'b1010;
    #1;
    check("bus_oe_prio_data", 32'(data), 32'h34);
    data_oe_in = 4'b1000;
    #1;
    check("bus_oe3_data", 32'(data), 32'hFF);
    data_oe_in = 4'b0000;
    #1;
    check("bus_and_data", 32'(data), 32'h10);
    check("bus_and_rq", 32'(data_oe_rq), 32'(1'b0));

    // Round robin with both requesters held: 0, 1, 0.
    ram_bus.ram_req = 2'b11;
    do_rr("rr0", 0, ADDR0);
    do_rr("rr1", 1, ADDR1);
    do_rr("rr2", 0, ADDR0);

    // Timeout on requester 1: err+gnt exactly 5 cycles after ram_cs.
    tick();
    check("to_issue_cs", 32'(ram_bus.ram_cs), 32'(1'b1));
    check("to_issue_addr", 32'(ram_bus.ram_addr), 32'(ADDR1));
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("to_wait%0d_err", c), 32'(ram_bus.ram_err), 32'(1'b0));
      check($sformatf("to_wait%0d_gnt", c), 32'(ram_bus.ram_gnt), 32'(0));
    end
    tick();
    check("to_err", 32'(ram_bus.ram_err), 32'(1'b1));
    check("to_gnt", 32'(ram_bus.ram_gnt), 32'(2'b10));
    tick();
    check("to_after_err", 32'(ram_bus.ram_err), 32'(1'b0));
    check("to_after_gnt", 32'(ram_bus.ram_gnt), 32'(0));
    do_rr("to_next", 0, ADDR0);

    // Reset during requester 1's WAIT, with last grant at 0.
    tick();
    check("ar_issue_addr", 32'(ram_bus.ram_addr), 32'(ADDR1));
    tick();
    #2;
    ram_bus.ram_ready = 1'b1;
    reset_n           = 1'b0;
    #1;
    check("ar_cs", 32'(ram_bus.ram_cs), 32'(1'b0));
    check("ar_addr", 32'(ram_bus.ram_addr), 32'(0));
    check("ar_gnt", 32'(ram_bus.ram_gnt), 32'(0));
    check("ar_err", 32'(ram_bus.ram_err), 32'(1'b0));
    check("ar_sound", 32'(sound), 32'(0));
    check("ar_sat", 32'(sat), 32'(1'b0));
    ram_bus.ram_ready = 1'b0;
    tick();
    reset_n = 1'b1;
    do_rr("ar_first", 0, ADDR0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
